// File: rtl/freq_sweep_ctrl.sv
// Frequency control word sequencer: manual up/down stepping plus an automatic sweep that logs one settled measurement per word.
// Latency: a manual step or sweep start shows on freq_ctrl one edge after the input edge. A log write follows meas_valid by one cycle.
// Backpressure: none. meas_valid pulses are used as they arrive. Defining SWEEP_TIMEOUT_EN adds a per-state watchdog.
module freq_sweep_ctrl #(
    parameter int CTRL_MIN       = 1,
    parameter int CTRL_MAX       = 128,
    parameter int SETTLE_MEAS    = 1,
    parameter int TIMEOUT_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_pb,
    input  logic        dec_pb,
    input  logic        sweep_start,
    input  logic        sweep_stop,
    input  logic        sweep_dir,
    input  logic        meas_valid,
    input  logic [31:0] meas_value,
    output logic [7:0]  freq_ctrl,
    output logic        busy,
    output logic        log_wr,
    output logic [6:0]  log_addr,
    output logic [31:0] log_data,
    output logic        sweep_done
);
    localparam logic [7:0] MIN_W = 8'(CTRL_MIN);
    localparam logic [7:0] MAX_W = 8'(CTRL_MAX);
    localparam int SCW = (SETTLE_MEAS > 1) ? $clog2(SETTLE_MEAS) : 1;
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'((SETTLE_MEAS > 0) ? SETTLE_MEAS - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, STEP} state_t;
    state_t state_q, state_d;

    logic           inc_prev, dec_prev, start_prev;
    logic           inc_edge, dec_edge, start_edge;
    logic           dir_q, dir_d;
    logic [SCW-1:0] settle_cnt_q, settle_cnt_d;
    logic [7:0]     freq_d;
    logic           log_wr_d, done_d;
    logic [6:0]     log_addr_d;
    logic [31:0]    log_data_d;
    logic           timeout;

    assign inc_edge   = inc_pb & ~inc_prev;
    assign dec_edge   = dec_pb & ~dec_prev;
    assign start_edge = sweep_start & ~start_prev;
    assign busy       = (state_q != IDLE);

`ifdef SWEEP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            to_cnt <= '0;
        else if (state_d != state_q)
            to_cnt <= '0;
        else if (busy)
            to_cnt <= to_cnt + 1'b1;
    end

    assign timeout = ((state_q == SETTLE) || (state_q == MEASURE)) &&
                     (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        freq_d       = freq_ctrl;
        dir_d        = dir_q;
        settle_cnt_d = settle_cnt_q;
        log_wr_d     = 1'b0;
        log_addr_d   = log_addr;
        log_data_d   = log_data;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                // Sweep start takes priority; a coincident button edge is dropped.
                if (start_edge) begin
                    freq_d       = sweep_dir ? MAX_W : MIN_W;
                    dir_d        = sweep_dir;
                    settle_cnt_d = '0;
                    state_d      = SETTLE;
                end else if (inc_edge) begin
                    freq_d = (freq_ctrl >= MAX_W) ? MIN_W : freq_ctrl + 8'd1;
                end else if (dec_edge) begin
                    freq_d = (freq_ctrl <= MIN_W) ? MAX_W : freq_ctrl - 8'd1;
                end
            end
            SETTLE: begin
                if (sweep_stop) begin
                    state_d = IDLE;
                end else if (SETTLE_MEAS == 0) begin
                    state_d = MEASURE;
                end else if (meas_valid) begin
                    if (settle_cnt_q == SETTLE_LAST)
                        state_d = MEASURE;
                    else
                        settle_cnt_d = settle_cnt_q + 1'b1;
                end else if (timeout) begin
                    log_wr_d   = 1'b1;
                    log_addr_d = 7'(freq_ctrl - MIN_W);
                    log_data_d = 32'hFFFF_FFFF;
                    state_d    = STEP;
                end
            end
            MEASURE: begin
                if (sweep_stop) begin
                    state_d = IDLE;
                end else if (meas_valid || timeout) begin
                    log_wr_d   = 1'b1;
                    log_addr_d = 7'(freq_ctrl - MIN_W);
                    log_data_d = meas_valid ? meas_value : 32'hFFFF_FFFF;
                    state_d    = STEP;
                end
            end
            STEP: begin
                if (sweep_stop) begin
                    state_d = IDLE;
                end else if (dir_q ? (freq_ctrl <= MIN_W) : (freq_ctrl >= MAX_W)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    freq_d       = dir_q ? freq_ctrl - 8'd1 : freq_ctrl + 8'd1;
                    settle_cnt_d = '0;
                    state_d      = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            freq_ctrl    <= MIN_W;
            dir_q        <= 1'b0;
            settle_cnt_q <= '0;
            log_wr       <= 1'b0;
            log_addr     <= '0;
            log_data     <= '0;
            sweep_done   <= 1'b0;
            inc_prev     <= 1'b0;
            dec_prev     <= 1'b0;
            start_prev   <= 1'b0;
        end else begin
            state_q      <= state_d;
            freq_ctrl    <= freq_d;
            dir_q        <= dir_d;
            settle_cnt_q <= settle_cnt_d;
            log_wr       <= log_wr_d;
            log_addr     <= log_addr_d;
            log_data     <= log_data_d;
            sweep_done   <= done_d;
            inc_prev     <= inc_pb;
            dec_prev     <= dec_pb;
            start_prev   <= sweep_start;
        end
    end
endmodule

// File: doc/freq_sweep_ctrl.md
# freq_sweep_ctrl

Sequencer that owns the wave generator's frequency control word. It applies manual up/down step requests, and runs an automatic sweep across the full control range. At each step the sweep waits for the frequency meter to settle, captures one measurement, and writes it to a result log. It sits between the push-button/switch layer and the `wave_generator` / `freq_measure` pair, in the 100 kHz clock domain.

## Interface
Parameters:
- `CTRL_MIN`, default 1: lowest frequency control word.
- `CTRL_MAX`, default 128: highest frequency control word.
- `SETTLE_MEAS`, default 1: number of `meas_valid` pulses discarded after each step.
- `TIMEOUT_CYCLES`, default 250000: watchdog limit per step. Used only with `SWEEP_TIMEOUT_EN`.

Ports:
- `clk` in, 1: 100 kHz system clock. One clock; everything is synchronous to its rising edge.
- `rst` in, 1: reset. Synchronous, active-high.
- `inc_pb` in, 1: manual increment request. Level input, already debounced; acts on its rising edge.
- `dec_pb` in, 1: manual decrement request. Same conditioning as `inc_pb`.
- `sweep_start` in, 1: starts a sweep on its rising edge.
- `sweep_stop` in, 1: aborts a sweep, level-sensitive.
- `sweep_dir` in, 1: 0 = sweep up, 1 = sweep down. Sampled at start.
- `meas_valid` in, 1: one-cycle pulse from the frequency meter at the end of each gate window.
- `meas_value` in, 32: measured frequency. Valid while `meas_valid` = 1.
- `freq_ctrl` out, 8: registered control word to the wave generator.
- `busy` out, 1: high while a sweep is in progress.
- `log_wr` out, 1: one-cycle write strobe to the result log.
- `log_addr` out, 7: log address, equal to `freq_ctrl - CTRL_MIN` for the logged step.
- `log_data` out, 32: logged measurement.
- `sweep_done` out, 1: one-cycle pulse when a sweep completes normally.

## Operation
- Reset values:
  - `freq_ctrl` = `CTRL_MIN`.
  - `busy`, `log_wr`, `log_addr`, `log_data`, `sweep_done` = 0.
  - State = IDLE; all edge-detect history = 0.
- Rising edges are detected as `in & ~prev`, with `prev` registered every cycle in all states.

States:
- IDLE, manual control:
  - An `inc_pb` edge steps `freq_ctrl` +1; `CTRL_MAX` wraps to `CTRL_MIN`.
  - A `dec_pb` edge steps `freq_ctrl` -1; `CTRL_MIN` wraps to `CTRL_MAX`.
  - If both edges occur in the same cycle, increment wins.
  - A `sweep_start` edge loads `freq_ctrl` = `CTRL_MIN` (dir 0) or `CTRL_MAX` (dir 1), latches the direction, clears the discard counter, and goes to SETTLE.
  - If `sweep_start` and a button edge occur in the same cycle, `sweep_start` wins and the button edge is dropped.
- SETTLE: count `meas_valid` pulses. After `SETTLE_MEAS` pulses, go to MEASURE. If `SETTLE_MEAS` = 0, go straight to MEASURE.
- MEASURE: on `meas_valid`:
  - Drive `log_wr` = 1 for one cycle, with `log_data` = `meas_value` and `log_addr` = `freq_ctrl - CTRL_MIN`.
  - Go to STEP.
- STEP, one cycle:
  - If `freq_ctrl` has reached the end value (`CTRL_MAX` going up, `CTRL_MIN` going down), pulse `sweep_done` and go to IDLE.
  - Otherwise move `freq_ctrl` ±1 and go to SETTLE.
- `busy` = 1 in SETTLE, MEASURE and STEP.
- Manual button edges are ignored while `busy` = 1. They are not queued.
- `sweep_stop` = 1 in any busy state: go to IDLE on the next edge.
  - `freq_ctrl` holds its current value.
  - No `log_wr` and no `sweep_done`.
  - If stop coincides with a `meas_valid` in MEASURE, stop wins and nothing is logged.
- `sweep_start` edges while busy are ignored.
- Arithmetic: `freq_ctrl` is 8 bits and is never driven outside [`CTRL_MIN`, `CTRL_MAX`]. `log_addr` is 7 bits.

## Timing
- A manual step is visible on `freq_ctrl` after the same clock edge that samples the request edge (one-cycle latency from the input going high).
- Sweep start: `freq_ctrl` takes the start value and `busy` rises on the edge that samples `sweep_start` high.
- `log_wr`, `log_addr` and `log_data` are registered. They are asserted the cycle after the `meas_valid` cycle and held for exactly one cycle. `log_addr` and `log_data` keep their last values afterwards.
- STEP occupies the cycle after the log write. The new `freq_ctrl` appears one cycle after `log_wr`.
- `sweep_done` is asserted in the cycle after the final `log_wr`. `busy` falls on the same edge.
- A sweep of N words with `SETTLE_MEAS` = 1 produces exactly N `log_wr` pulses and consumes 2N `meas_valid` pulses.
- Reset asserted mid-sweep restores all reset values on the next edge. No done pulse is produced.

## Configuration
- `SWEEP_TIMEOUT_EN` defined:
  - A per-step counter runs in SETTLE and MEASURE and is cleared on every state entry.
  - When it reaches `TIMEOUT_CYCLES` with no qualifying `meas_valid`, the block logs `log_data` = 32'hFFFF_FFFF at the current address, goes to STEP, and the sweep continues.
- `SWEEP_TIMEOUT_EN` undefined: no counter is built, and SETTLE and MEASURE wait indefinitely.

## Test plan
- Reset, then 128 `inc_pb` edges: `freq_ctrl` runs 2…128, then wraps to 1. One `dec_pb` edge from 1 gives 128.
- `inc_pb` and `dec_pb` edges in the same cycle at `freq_ctrl` = 5: result is 6.
- Up sweep with `sweep_dir` = 0 and `meas_valid` every 100 cycles with `meas_value` = 1000×`freq_ctrl`:
  - 128 `log_wr` pulses.
  - `log_addr` 0…127; `log_data` at address k = 1000×(k+1).
  - One `sweep_done`; final `freq_ctrl` = 128.
- Down sweep with `sweep_stop` raised after the 10th `log_wr`:
  - `busy` drops next cycle and `freq_ctrl` holds (118 or 119 depending on phase).
  - No further `log_wr`; no `sweep_done`.
- Press `inc_pb` during a sweep: no change to the sweep sequence. `rst` mid-sweep: `freq_ctrl` = 1 and `busy` = 0 next cycle.
- With `SWEEP_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 50, starve `meas_valid`: a `log_wr` with data 32'hFFFF_FFFF every 51 cycles, addresses advancing. Without the macro, `busy` stays 1 and no `log_wr` occurs.
